mvb_item_serializer: RTL and testbench



---
 rtl/mvb_item_serializer.sv | 86 ++++++++
 tb/tb_mvb_item_serializer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/mvb_item_serializer.sv
// rtl/mvb_item_serializer.sv - multi-region MVB word to one-item-per-cycle MVB serializer
// Optional TX_LAST/TX_REGION outputs are enabled by defining MVB_ITEM_SERIALIZER_LAST_EN.
module mvb_item_serializer #(
  parameter int REGIONS    = 4,
  parameter int ITEM_WIDTH = 8
) (
  input  logic                                         CLK,
  input  logic                                         RESET,
  input  logic [REGIONS*ITEM_WIDTH-1:0]                RX_DATA,
  input  logic [REGIONS-1:0]                           RX_VLD,
  input  logic                                         RX_SRC_RDY,
  output logic                                         RX_DST_RDY,
  output logic [ITEM_WIDTH-1:0]                        TX_DATA,
  output logic                                         TX_VLD,
  output logic                                         TX_SRC_RDY,
`ifdef MVB_ITEM_SERIALIZER_LAST_EN
  output logic                                         TX_LAST,
  output logic [((REGIONS > 1) ? $clog2(REGIONS) : 1)-1:0] TX_REGION,
`endif
  input  logic                                         TX_DST_RDY
);

  logic [REGIONS*ITEM_WIDTH-1:0] word_reg;
  logic [REGIONS-1:0]            pend_mask;
  logic [REGIONS-1:0]            sel_onehot;
  logic [ITEM_WIDTH-1:0]         sel_data;
  logic                          single_left;
  logic                          rx_fire;
  logic                          tx_fire;

`ifdef MVB_ITEM_SERIALIZER_LAST_EN
  localparam int SEL_W = (REGIONS > 1) ? $clog2(REGIONS) : 1;
  logic [SEL_W-1:0] sel;
`endif

  // Two's-complement trick isolates the lowest pending region.
  assign sel_onehot  = pend_mask & (~pend_mask + REGIONS'(1));
  assign single_left = (pend_mask != '0) && ((pend_mask & (pend_mask - REGIONS'(1))) == '0);

  assign TX_SRC_RDY = (pend_mask != '0);
  assign TX_VLD     = TX_SRC_RDY;
  assign RX_DST_RDY = (pend_mask == '0) || (single_left && TX_DST_RDY);

  assign rx_fire = RX_SRC_RDY && RX_DST_RDY;
  assign tx_fire = TX_SRC_RDY && TX_DST_RDY;

  always_comb begin
    sel_data = '0;
`ifdef MVB_ITEM_SERIALIZER_LAST_EN
    sel = '0;
`endif
    for (int i = REGIONS - 1; i >= 0; i--) begin
      if (pend_mask[i]) begin
        sel_data = word_reg[i*ITEM_WIDTH +: ITEM_WIDTH];
`ifdef MVB_ITEM_SERIALIZER_LAST_EN
        sel = SEL_W'(i);
`endif
      end
    end
  end

  assign TX_DATA = sel_data;

`ifdef MVB_ITEM_SERIALIZER_LAST_EN
  assign TX_LAST   = single_left;
  assign TX_REGION = sel;
`endif

  // A new word overwrites the mask even while its last item leaves, so there is no bubble.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      pend_mask <= '0;
    end else if (rx_fire) begin
      pend_mask <= RX_VLD;
    end else if (tx_fire) begin
      pend_mask <= pend_mask & ~sel_onehot;
    end
  end

  always_ff @(posedge CLK) begin
    if (rx_fire) begin
      word_reg <= RX_DATA;
    end
  end

endmodule

// File: tb/tb_mvb_item_serializer.sv
// tb/tb_mvb_item_serializer.sv - scoreboard bench for mvb_item_serializer, REGIONS in {1,4,8}
// TX_LAST/TX_REGION are also checked when MVB_ITEM_SERIALIZER_LAST_EN is defined.
module tb_mvb_item_serializer;

  typedef struct {
    logic [7:0] d;
    int         r;
  } item_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  function automatic void chk(input string nm, input int cfg, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s cfg=%0d actual=%0h required=%0h", nm, cfg, act, req);
    end
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_cfg
    localparam int R = (g == 0) ? 1 : (g == 1) ? 4 : 8;

    logic [R*8-1:0] rx_data;
    logic [R-1:0]   rx_vld;
    logic           rx_src_rdy;
    logic           rx_dst_rdy;
    logic [7:0]     tx_data;
    logic           tx_vld;
    logic           tx_src_rdy;
    logic           tx_dst_rdy;
`ifdef MVB_ITEM_SERIALIZER_LAST_EN
    localparam int SW = (R > 1) ? $clog2(R) : 1;
    logic           tx_last;
    logic [SW-1:0]  tx_region;
`endif

    item_t q[$];
    int    acc_cnt = 0;
    bit    done = 1'b0;
    bit    mid_flag = 1'b0;

    mvb_item_serializer #(.REGIONS(R), .ITEM_WIDTH(8)) dut (
      .CLK        (clk),
      .RESET      (rst),
      .RX_DATA    (rx_data),
      .RX_VLD     (rx_vld),
      .RX_SRC_RDY (rx_src_rdy),
      .RX_DST_RDY (rx_dst_rdy),
      .TX_DATA    (tx_data),
      .TX_VLD     (tx_vld),
      .TX_SRC_RDY (tx_src_rdy),
`ifdef MVB_ITEM_SERIALIZER_LAST_EN
      .TX_LAST    (tx_last),
      .TX_REGION  (tx_region),
`endif
      .TX_DST_RDY (tx_dst_rdy)
    );

    // Model: the queue holds the not-yet-sent items of the current word.
    always @(negedge clk) begin
      bit exp_rdy;
      if (rst) begin
        q.delete();
      end else begin
        exp_rdy = (q.size() == 0) || (q.size() == 1 && tx_dst_rdy);
        chk("tx_vld_eq_src_rdy", g, 64'(tx_vld), 64'(tx_src_rdy));
        chk("tx_src_rdy", g, 64'(tx_src_rdy), 64'(q.size() != 0));
        chk("rx_dst_rdy", g, 64'(rx_dst_rdy), 64'(exp_rdy));
        if (q.size() != 0) begin
          chk("tx_data", g, 64'(tx_data), 64'(q[0].d));
`ifdef MVB_ITEM_SERIALIZER_LAST_EN
          chk("tx_last", g, 64'(tx_last), 64'(q.size() == 1));
          chk("tx_region", g, 64'(tx_region), 64'(q[0].r));
`endif
          if (tx_dst_rdy) void'(q.pop_front());
        end
        if (rx_src_rdy && exp_rdy) begin
          acc_cnt++;
          for (int i = 0; i < R; i++)
            if (rx_vld[i]) q.push_back('{rx_data[i*8 +: 8], i});
        end
      end
    end

    task automatic step(input logic s, input logic [63:0] d, input logic [7:0] v, input logic t);
      rx_src_rdy = s;
      rx_data    = d[R*8-1:0];
      rx_vld     = v[R-1:0];
      tx_dst_rdy = t;
      @(posedge clk);
      #1;
    endtask

    task automatic send_word(input logic [63:0] d, input logic [7:0] v, input logic t, output int tries);
      int c0 = acc_cnt;
      tries = 0;
      while (acc_cnt == c0 && tries < 64) begin
        step(1'b1, d, v, t);
        tries++;
      end
      chk("accept_in_time", g, 64'(acc_cnt != c0), 64'(1));
    endtask

    initial begin : drive
      int          tries;
      int          c_last;
      logic [63:0] hd;
      logic [7:0]  hv;
      rx_src_rdy = 1'b0;
      rx_data    = '0;
      rx_vld     = '0;
      tx_dst_rdy = 1'b1;
      wait (rst == 1'b0);
      @(posedge clk);
      #1;
      if (g == 1) begin
        send_word(64'h44332211, 8'hF, 1'b1, tries);
        repeat (5) step(1'b0, 64'h0, 8'h0, 1'b1);
        send_word(64'hDDCCBBAA, 8'hA, 1'b1, tries);
        repeat (3) step(1'b0, 64'h0, 8'h0, 1'b1);
        send_word(64'h04030201, 8'hF, 1'b1, tries);
        send_word(64'h08070605, 8'h3, 1'b1, tries);
        repeat (7) step(1'b0, 64'h0, 8'h0, 1'b1);
        send_word(64'h0, 8'h0, 1'b1, tries);
        chk("empty_word_cycles", g, 64'(tries), 64'(1));
        send_word(64'h1234565A, 8'h1, 1'b0, tries);
        chk("bp_word_cycles", g, 64'(tries), 64'(1));
        repeat (5) step(1'b0, 64'hFFFF, 8'hF, 1'b0);
        repeat (2) step(1'b0, 64'h0, 8'h0, 1'b1);
        send_word(64'hA4A3A2A1, 8'hF, 1'b1, tries);
        step(1'b0, 64'h0, 8'h0, 1'b1);
        mid_flag = 1'b1;
        wait (rst == 1'b1);
        wait (rst == 1'b0);
        @(posedge clk);
        #1;
        send_word(64'hB4B3B2B1, 8'hF, 1'b1, tries);
        repeat (6) step(1'b0, 64'h0, 8'h0, 1'b1);
      end
      c_last = acc_cnt;
      hd = {$urandom(), $urandom()};
      hv = 8'($urandom());
      for (int n = 0; n < 1500; n++) begin
        if (acc_cnt != c_last) begin
          c_last = acc_cnt;
          hd = {$urandom(), $urandom()};
          hv = ($urandom_range(0, 5) == 0) ? 8'h0 : 8'($urandom());
        end
        if ($urandom_range(0, 3) != 0)
          step(1'b1, hd, hv, 1'($urandom_range(0, 2) != 0));
        else
          step(1'b0, {$urandom(), $urandom()}, 8'($urandom()), 1'($urandom_range(0, 2) != 0));
      end
      repeat (R + 3) step(1'b0, 64'h0, 8'h0, 1'b1);
      chk("drained", g, 64'(q.size()), 64'(0));
      done = 1'b1;
    end
  end

  initial begin
    #12;
    chk("reset_tx_src_rdy", 1, 64'(g_cfg[1].tx_src_rdy), 64'(0));
    chk("reset_tx_vld", 1, 64'(g_cfg[1].tx_vld), 64'(0));
    chk("reset_rx_dst_rdy", 1, 64'(g_cfg[1].rx_dst_rdy), 64'(1));
`ifdef MVB_ITEM_SERIALIZER_LAST_EN
    chk("reset_tx_last", 1, 64'(g_cfg[1].tx_last), 64'(0));
    chk("reset_tx_region", 1, 64'(g_cfg[1].tx_region), 64'(0));
`endif
    @(posedge clk);
    #3;
    rst = 1'b0;
    wait (g_cfg[1].mid_flag);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_tx_src_rdy", 1, 64'(g_cfg[1].tx_src_rdy), 64'(0));
    chk("midrst_tx_vld", 1, 64'(g_cfg[1].tx_vld), 64'(0));
    chk("midrst_rx_dst_rdy", 1, 64'(g_cfg[1].rx_dst_rdy), 64'(1));
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b0;
    wait (g_cfg[0].done && g_cfg[1].done && g_cfg[2].done);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=completion");
    $fatal(1, "watchdog expired");
  end

endmodule
